// File: rtl/snake_body_queue_if.sv
// Controller-side bundle for the snake body queue: step requests in, segment/status view out.
// The queue is the slave; the movement controller (or bench) is the master.
interface snake_body_queue_if #(
  parameter int XW = 6,
  parameter int YW = 5,
  parameter int AW = 11
);
  logic              restart;
  logic              tick;
  logic              eat;
  logic [XW+YW-1:0]  new_head_xy;
  logic              ready;
  logic [XW+YW-1:0]  head_xy;
  logic [XW+YW-1:0]  tail_xy;
  logic [AW:0]       length;
  logic              full;
  logic              overflow;
  logic              seed_valid;
  logic [XW+YW-1:0]  seed_xy;

  modport master (
    output restart, tick, eat, new_head_xy,
    input  ready, head_xy, tail_xy, length, full, overflow, seed_valid, seed_xy
  );

  modport slave (
    input  restart, tick, eat, new_head_xy,
    output ready, head_xy, tail_xy, length, full, overflow, seed_valid, seed_xy
  );
endinterface

// File: rtl/snake_body_queue.sv
// Circular queue of snake segments (tail oldest, head newest); seeds a straight snake after reset/restart.
// Push/pop take effect at the tick edge; tail_xy is a same-cycle read; a grow tick while full is dropped with an overflow pulse.
module snake_body_queue #(
  parameter int XW       = 6,
  parameter int YW       = 5,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int AW       = 11,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 20,
  parameter int START_Y  = 15
) (
  input  logic               clk,
  input  logic               reset,
  snake_body_queue_if.slave  q
);

  localparam int DW    = XW + YW;
  localparam int DEPTH = 1 << AW;
  localparam int LW    = AW + 1;

  localparam logic [LW-1:0] CAP    = LW'(GRID_W * GRID_H);
  localparam logic [XW-1:0] X0     = XW'(START_X - INIT_LEN + 1);
  localparam logic [YW-1:0] Y0     = YW'(START_Y);
  localparam logic [XW-1:0] K_LAST = XW'(INIT_LEN - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state;
  logic [XW-1:0]   k;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   length;
  logic [DW-1:0]   head_xy;
  logic            ready;
  logic            full;
  logic            overflow;

  logic [DW-1:0]   mem [DEPTH];

  logic            push;
  logic            pop;
  logic            grow;
  logic            ovf_hit;
  logic            seed_valid;
  logic [DW-1:0]   seed_xy;
  logic [DW-1:0]   wdata;
  logic [LW-1:0]   length_next;

  // Seeding and run-time pushes share the single write port; restart and reset suppress both.
  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    grow       = 1'b0;
    ovf_hit    = 1'b0;
    seed_valid = 1'b0;
    seed_xy    = '0;
    wdata      = q.new_head_xy;
    if (!reset && !q.restart) begin
      if (state == S_INIT) begin
        seed_valid = 1'b1;
        seed_xy    = {X0 + k, Y0};
        wdata      = {X0 + k, Y0};
        push       = 1'b1;
        grow       = 1'b1;
      end else if (q.tick) begin
        if (q.eat && full) begin
          ovf_hit = 1'b1;
        end else begin
          push = 1'b1;
          pop  = !q.eat;
          grow = q.eat;
        end
      end
    end
    length_next = length + {{AW{1'b0}}, grow};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      k        <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      length   <= '0;
      head_xy  <= '0;
      ready    <= 1'b0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else if (q.restart) begin
      state    <= S_INIT;
      k        <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      length   <= '0;
      ready    <= 1'b0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= ovf_hit;
      length   <= length_next;
      full     <= (length_next == CAP);
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        head_xy <= wdata;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (state == S_INIT) begin
        if (k == K_LAST) begin
          state <= S_RUN;
          ready <= 1'b1;
          k     <= '0;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  assign q.ready      = ready;
  assign q.head_xy    = head_xy;
  assign q.tail_xy    = mem[rd_ptr];
  assign q.length     = length;
  assign q.full       = full;
  assign q.overflow   = overflow;
  assign q.seed_valid = seed_valid;
  assign q.seed_xy    = seed_xy;

endmodule

// File: tb/tb_snake_body_queue.sv
// Directed bench: default-size queue for seeding/run/restart/reset, small AW=3 queue for wrap/full/overflow.
module tb_snake_body_queue;
  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  snake_body_queue_if #(.XW(6), .YW(5), .AW(11)) qa ();
  snake_body_queue_if #(.XW(6), .YW(5), .AW(3))  qb ();

  snake_body_queue dut_a (
    .clk   (clk),
    .reset (reset_a),
    .q     (qa.slave)
  );

  snake_body_queue #(
    .AW       (3),
    .GRID_W   (4),
    .GRID_H   (2),
    .INIT_LEN (1)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .q     (qb.slave)
  );

  function automatic logic [10:0] xy(input int x, input int y);
    return {x[5:0], y[4:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects dut_a in INIT at k=0; walks the three seeding cycles.
  task automatic seed_a(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_seed_vld"}, 32'(qa.seed_valid), 32'd1);
      chk({tag, "_seed_xy"},  32'(qa.seed_xy),    32'(xy(18 + k, 15)));
      chk({tag, "_seed_rdy"}, 32'(qa.ready),      32'd0);
      if (k == 2) qa.tick = 1'b0;
      step();
    end
    chk({tag, "_rdy"},    32'(qa.ready),      32'd1);
    chk({tag, "_len"},    32'(qa.length),     32'd3);
    chk({tag, "_head"},   32'(qa.head_xy),    32'(xy(20, 15)));
    chk({tag, "_tail"},   32'(qa.tail_xy),    32'(xy(18, 15)));
    chk({tag, "_sv_run"}, 32'(qa.seed_valid), 32'd0);
  endtask

  task automatic tick_a(input logic e, input logic [10:0] nh);
    qa.tick = 1'b1;
    qa.eat = e;
    qa.new_head_xy = nh;
    step();
    qa.tick = 1'b0;
    qa.eat = 1'b0;
  endtask

  initial begin
    logic [10:0] nh;
    reset_a = 1'b1;
    reset_b = 1'b1;
    qa.restart = 1'b0; qa.tick = 1'b0; qa.eat = 1'b0; qa.new_head_xy = '0;
    qb.restart = 1'b0; qb.tick = 1'b0; qb.eat = 1'b0; qb.new_head_xy = '0;
    repeat (2) step();

    chk("rst_ready",    32'(qa.ready),      32'd0);
    chk("rst_len",      32'(qa.length),     32'd0);
    chk("rst_head",     32'(qa.head_xy),    32'd0);
    chk("rst_full",     32'(qa.full),       32'd0);
    chk("rst_ovf",      32'(qa.overflow),   32'd0);
    chk("rst_seed_vld", 32'(qa.seed_valid), 32'd0);
    chk("rst_seed_xy",  32'(qa.seed_xy),    32'd0);
    chk("rst_b_len",    32'(qb.length),     32'd0);

    // Release reset; a tick held high through seeding must be ignored.
    reset_a = 1'b0;
    reset_b = 1'b0;
    qa.tick = 1'b1; qa.eat = 1'b1; qa.new_head_xy = xy(1, 1);
    #1;
    seed_a("init");

    chk("b_ready", 32'(qb.ready),   32'd1);
    chk("b_len",   32'(qb.length),  32'd1);
    chk("b_head",  32'(qb.head_xy), 32'(xy(20, 15)));
    chk("b_tail",  32'(qb.tail_xy), 32'(xy(20, 15)));

    // Move without eating: tail visible in the tick cycle, then advances.
    qa.tick = 1'b1; qa.eat = 1'b0; qa.new_head_xy = xy(21, 15);
    chk("mv_tail_now", 32'(qa.tail_xy), 32'(xy(18, 15)));
    step();
    qa.tick = 1'b0;
    chk("mv_head", 32'(qa.head_xy), 32'(xy(21, 15)));
    chk("mv_tail", 32'(qa.tail_xy), 32'(xy(19, 15)));
    chk("mv_len",  32'(qa.length),  32'd3);

    tick_a(1'b1, xy(21, 16));
    chk("eat_len",  32'(qa.length),  32'd4);
    chk("eat_tail", 32'(qa.tail_xy), 32'(xy(19, 15)));
    chk("eat_head", 32'(qa.head_xy), 32'(xy(21, 16)));
    chk("eat_full", 32'(qa.full),    32'd0);
    tick_a(1'b1, xy(22, 16));
    chk("eat2_len", 32'(qa.length),  32'd5);

    // restart wins over a simultaneous tick.
    qa.restart = 1'b1; qa.tick = 1'b1; qa.eat = 1'b0; qa.new_head_xy = xy(5, 5);
    step();
    qa.restart = 1'b0; qa.tick = 1'b0;
    #1;
    chk("rs_len",   32'(qa.length),   32'd0);
    chk("rs_ready", 32'(qa.ready),    32'd0);
    chk("rs_full",  32'(qa.full),     32'd0);
    chk("rs_ovf",   32'(qa.overflow), 32'd0);
    seed_a("rs");

    tick_a(1'b1, xy(21, 15));
    tick_a(1'b1, xy(22, 15));
    chk("pre_rst_len", 32'(qa.length), 32'd5);

    // Short async reset pulse between clock edges.
    reset_a = 1'b1;
    #1;
    chk("arst_len",   32'(qa.length),     32'd0);
    chk("arst_ready", 32'(qa.ready),      32'd0);
    chk("arst_head",  32'(qa.head_xy),    32'd0);
    chk("arst_sv",    32'(qa.seed_valid), 32'd0);
    #1;
    reset_a = 1'b0;
    #1;
    seed_a("arst");

    // Small build: wrap the pointers with a length-1 snake.
    for (int i = 0; i < 20; i++) begin
      nh = xy(i + 1, i % 8);
      qb.tick = 1'b1; qb.eat = 1'b0; qb.new_head_xy = nh;
      step();
      chk("wrap_tail", 32'(qb.tail_xy), 32'(nh));
      chk("wrap_head", 32'(qb.head_xy), 32'(nh));
      chk("wrap_len",  32'(qb.length),  32'd1);
    end
    for (int j = 0; j < 7; j++) begin
      qb.tick = 1'b1; qb.eat = 1'b1; qb.new_head_xy = xy(30 + j, j);
      step();
      chk("grow_len",  32'(qb.length),  32'(j + 2));
      chk("grow_full", 32'(qb.full),    (j == 6) ? 32'd1 : 32'd0);
      chk("grow_tail", 32'(qb.tail_xy), 32'(xy(20, 3)));
    end
    qb.tick = 1'b1; qb.eat = 1'b1; qb.new_head_xy = xy(50, 3);
    step();
    qb.tick = 1'b0; qb.eat = 1'b0;
    chk("ovf_pulse", 32'(qb.overflow), 32'd1);
    chk("ovf_len",   32'(qb.length),   32'd8);
    chk("ovf_head",  32'(qb.head_xy),  32'(xy(36, 6)));
    chk("ovf_tail",  32'(qb.tail_xy),  32'(xy(20, 3)));
    step();
    chk("ovf_clear", 32'(qb.overflow), 32'd0);
    chk("ovf_len2",  32'(qb.length),   32'd8);

    // A non-eating move while full is still a legal push+pop.
    qb.tick = 1'b1; qb.eat = 1'b0; qb.new_head_xy = xy(51, 4);
    step();
    qb.tick = 1'b0;
    chk("fullmv_len",  32'(qb.length),   32'd8);
    chk("fullmv_full", 32'(qb.full),     32'd1);
    chk("fullmv_head", 32'(qb.head_xy),  32'(xy(51, 4)));
    chk("fullmv_tail", 32'(qb.tail_xy),  32'(xy(30, 0)));
    chk("fullmv_ovf",  32'(qb.overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
